// File: rtl/pc_fetch_unit.sv
// Program-counter register and single-word instruction fetch sequencer (FETCH/WAIT/HOLD).
// Optional retire counter output fetch_count is built when PC_FETCH_CNT_EN is defined.
module pc_fetch_unit #(
  parameter int unsigned         ADDR_W   = 16,
  parameter int unsigned         DATA_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc,
  output logic              bram_rd_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              flush,
  input  logic              halt
`ifdef PC_FETCH_CNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;

  // A flush in FETCH redirects the PC instead of reading the stale address.
  // Gating with rst_n keeps the strobe low while reset is held.
  assign bram_rd_en  = rst_n && (state_q == ST_FETCH) && !halt && !flush;
  assign bram_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      ST_FETCH: begin
        if (flush) begin
          pc_d = pc_next;
        end else if (!halt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          pc_d    = pc_next;
          state_d = ST_FETCH;
        end else begin
          instr_d = bram_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush || instr_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_next;
          state_d = ST_FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_FETCH;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef PC_FETCH_CNT_EN
  logic        retire;
  logic [15:0] cnt_q;

  // Only words actually consumed by the engine are counted; flush wins over ready.
  assign retire      = (state_q == ST_HOLD) && instr_ready && !flush;
  assign fetch_count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_next;
  logic [15:0] pc;
  logic        bram_rd_en;
  logic [15:0] bram_addr;
  logic [15:0] bram_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        flush = 1'b0;
  logic        halt = 1'b0;
`ifdef PC_FETCH_CNT_EN
  logic [15:0] fetch_count;
`endif

  // pc_mux stand-in plus a raw override used to reach addresses the 8-bit immediate cannot.
  logic        mux_en = 1'b0;
  logic [7:0]  imm = '0;
  logic        raw_en = 1'b0;
  logic [15:0] raw_val = '0;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int failures = 0;

  // Reference model: one fetch transaction at a time.
  logic [15:0] m_pc, m_instr, m_cnt;
  logic        m_valid, m_inflight;

  pc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_next    (pc_next),
    .pc         (pc),
    .bram_rd_en (bram_rd_en),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .flush      (flush),
    .halt       (halt)
`ifdef PC_FETCH_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    if (raw_en) pc_next = raw_val;
    else if (mux_en) pc_next = {8'h00, imm};
    else pc_next = pc + 16'd1;
  end

  always @(posedge clk) begin
    if (bram_rd_en) bram_rdata <= mem[bram_addr];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = 16'h0000;
    m_instr    = 16'h0000;
    m_cnt      = 16'h0000;
    m_valid    = 1'b0;
    m_inflight = 1'b0;
  endtask

  task automatic drive(input logic h, input logic f, input logic r, input logic me,
                       input logic [7:0] im, input logic re, input logic [15:0] rv);
    halt = h; flush = f; instr_ready = r; mux_en = me; imm = im; raw_en = re; raw_val = rv;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 8'h00, 0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 16'h0000);
    check("rst_rd_en", {15'd0, bram_rd_en}, 16'd0);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_instr", instr, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive at negedge, compare model outputs, advance model on the rising edge.
  task automatic step(input logic h, input logic f, input logic r, input logic me,
                      input logic [7:0] im, input logic re, input logic [15:0] rv);
    logic [15:0] nxt;
    logic        idle;
    drive(h, f, r, me, im, re, rv);
    nxt  = re ? rv : (me ? {8'h00, im} : m_pc + 16'd1);
    idle = !m_inflight && !m_valid;
    #1;
    check("pc", pc, m_pc);
    check("bram_addr", bram_addr, m_pc);
    check("rd_en", {15'd0, bram_rd_en}, {15'd0, idle && !h && !f});
    check("valid", {15'd0, instr_valid}, {15'd0, m_valid});
    check("instr", instr, m_instr);
`ifdef PC_FETCH_CNT_EN
    check("fetch_count", fetch_count, m_cnt);
`endif
    @(posedge clk);
    if (m_inflight) begin
      m_inflight = 1'b0;
      if (f) m_pc = nxt;
      else begin
        m_instr = mem[m_pc];
        m_valid = 1'b1;
      end
    end else if (m_valid) begin
      if (f || r) begin
        m_valid = 1'b0;
        m_pc    = nxt;
        if (!f) m_cnt = m_cnt + 16'd1;
      end
    end else begin
      if (f) m_pc = nxt;
      else if (!h) m_inflight = 1'b1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        h, f, r, me;
    logic [7:0]  im;
    logic [15:0] e_pc;
    logic        e_rd, e_v;
    logic [15:0] e_instr, e_cnt;
  } vec_t;

  vec_t tbl [19];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[16'h0000] = 16'hA001;
    mem[16'h0001] = 16'hB002;
    mem[16'h0040] = 16'hC040;

    //            h  f  r  me imm     pc        rd v  instr     cnt
    tbl[0]  = '{0, 0, 1, 0, 8'h00, 16'h0000, 1, 0, 16'h0000, 16'd0};
    tbl[1]  = '{0, 0, 1, 0, 8'h00, 16'h0000, 0, 0, 16'h0000, 16'd0};
    tbl[2]  = '{0, 0, 1, 0, 8'h00, 16'h0000, 0, 1, 16'hA001, 16'd0};
    tbl[3]  = '{0, 0, 0, 0, 8'h00, 16'h0001, 1, 0, 16'hA001, 16'd1};
    tbl[4]  = '{0, 0, 0, 0, 8'h00, 16'h0001, 0, 0, 16'hA001, 16'd1};
    tbl[5]  = '{0, 0, 0, 0, 8'h00, 16'h0001, 0, 1, 16'hB002, 16'd1};
    tbl[6]  = '{0, 0, 0, 0, 8'h00, 16'h0001, 0, 1, 16'hB002, 16'd1};
    tbl[7]  = '{1, 0, 0, 0, 8'h00, 16'h0001, 0, 1, 16'hB002, 16'd1};
    tbl[8]  = '{1, 0, 0, 0, 8'h00, 16'h0001, 0, 1, 16'hB002, 16'd1};
    tbl[9]  = '{0, 0, 0, 0, 8'h00, 16'h0001, 0, 1, 16'hB002, 16'd1};
    tbl[10] = '{0, 0, 1, 0, 8'h00, 16'h0001, 0, 1, 16'hB002, 16'd1};
    tbl[11] = '{0, 0, 1, 0, 8'h00, 16'h0002, 1, 0, 16'hB002, 16'd2};
    tbl[12] = '{0, 1, 1, 1, 8'h40, 16'h0002, 0, 0, 16'hB002, 16'd2};
    tbl[13] = '{0, 0, 0, 0, 8'h00, 16'h0040, 1, 0, 16'hB002, 16'd2};
    tbl[14] = '{0, 0, 0, 0, 8'h00, 16'h0040, 0, 0, 16'hB002, 16'd2};
    tbl[15] = '{0, 1, 1, 0, 8'h00, 16'h0040, 0, 1, 16'hC040, 16'd2};
    tbl[16] = '{1, 0, 0, 0, 8'h00, 16'h0041, 0, 0, 16'hC040, 16'd2};
    tbl[17] = '{0, 1, 0, 1, 8'h10, 16'h0041, 0, 0, 16'hC040, 16'd2};
    tbl[18] = '{0, 0, 0, 0, 8'h00, 16'h0010, 1, 0, 16'hC040, 16'd2};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].h, tbl[i].f, tbl[i].r, tbl[i].me, tbl[i].im, 0, 16'h0000);
      #1;
      check($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      check($sformatf("vec%0d_addr", i), bram_addr, tbl[i].e_pc);
      check($sformatf("vec%0d_rd_en", i), {15'd0, bram_rd_en}, {15'd0, tbl[i].e_rd});
      check($sformatf("vec%0d_valid", i), {15'd0, instr_valid}, {15'd0, tbl[i].e_v});
      check($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
`ifdef PC_FETCH_CNT_EN
      check($sformatf("vec%0d_cnt", i), fetch_count, tbl[i].e_cnt);
`endif
      @(negedge clk);
    end

    // PC wrap: park pc at FFFF via flush, then retire with the +1 path.
    do_reset();
    step(0, 1, 0, 0, 8'h00, 1, 16'hFFFF);
    step(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    step(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    step(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    drive(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    #1;
    check("wrap_pc", pc, 16'h0000);
    check("wrap_addr", bram_addr, 16'h0000);
    check("wrap_rd_en", {15'd0, bram_rd_en}, 16'd1);
    check("wrap_instr", instr, 16'hFFFF ^ 16'h5A5A);
    @(negedge clk);

    // Asynchronous reset while a read is in flight.
    do_reset();
    step(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    step(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    step(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    step(0, 0, 1, 0, 8'h00, 0, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 16'h0000);
    check("arst_rd_en", {15'd0, bram_rd_en}, 16'd0);
    check("arst_valid", {15'd0, instr_valid}, 16'd0);
    check("arst_instr", instr, 16'h0000);
    @(posedge clk);
    #1;
    check("arst_late_valid", {15'd0, instr_valid}, 16'd0);
    check("arst_late_instr", instr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h00, 0, 16'h0000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 19) == 0,
           ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
